// File: rtl/svc_pkg.sv
// rtl/svc_pkg.sv - shared parameters, width helpers, FSM state and beat type for the sparse vector compressor
package svc_pkg;

  localparam int SVC_DATA_W  = 4;
  localparam int SVC_VEC_LEN = 16;
  localparam int SVC_MAX_RUN = 15;

  function automatic int svc_idx_w(input int max_run);
    return $clog2(max_run + 1);
  endfunction

  function automatic int svc_cnt_w(input int vec_len);
    return $clog2(vec_len + 1);
  endfunction

  localparam int SVC_IDX_W = svc_idx_w(SVC_MAX_RUN);
  localparam int SVC_CNT_W = svc_cnt_w(SVC_VEC_LEN);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } svc_state_e;

  typedef struct packed {
    logic [SVC_DATA_W*SVC_VEC_LEN-1:0] data;
    logic [SVC_IDX_W*SVC_VEC_LEN-1:0]  idx;
    logic [SVC_CNT_W-1:0]              cnt;
    logic                              last;
  } svc_beat_t;

endpackage

// File: rtl/svc_pack_kernel.sv
// rtl/svc_pack_kernel.sv - combinational zero-skip packer for one beat; mask output present under SVC_BITMASK_EN
module svc_pack_kernel
  import svc_pkg::*;
#(
  parameter int DATA_W  = SVC_DATA_W,
  parameter int VEC_LEN = SVC_VEC_LEN,
  parameter int MAX_RUN = SVC_MAX_RUN,
  parameter int IDX_W   = svc_idx_w(MAX_RUN),
  parameter int CNT_W   = svc_cnt_w(VEC_LEN)
) (
  input  logic [DATA_W*VEC_LEN-1:0] data_i,
  input  logic [IDX_W-1:0]          carry_run_i,
  output logic [DATA_W*VEC_LEN-1:0] data_o,
  output logic [IDX_W*VEC_LEN-1:0]  idx_o,
  output logic [CNT_W-1:0]          cnt_o,
`ifdef SVC_BITMASK_EN
  output logic [VEC_LEN-1:0]        mask_o,
`endif
  output logic [IDX_W-1:0]          next_run_o
);

  int                run_v;
  int                cnt_v;
  logic [DATA_W-1:0] elem;

  // A zero at run==MAX_RUN becomes a zero-valued cap entry so the index never overflows.
  always_comb begin
    data_o = '0;
    idx_o  = '0;
`ifdef SVC_BITMASK_EN
    mask_o = '0;
`endif
    run_v  = int'(carry_run_i);
    cnt_v  = 0;
    elem   = '0;
    for (int k = 0; k < VEC_LEN; k++) begin
      elem = data_i[k*DATA_W +: DATA_W];
      if (elem != '0 || run_v == MAX_RUN) begin
        data_o[cnt_v*DATA_W +: DATA_W] = elem;
        idx_o[cnt_v*IDX_W +: IDX_W]    = IDX_W'(run_v);
`ifdef SVC_BITMASK_EN
        mask_o[k] = 1'b1;
`endif
        cnt_v = cnt_v + 1;
        run_v = 0;
      end else begin
        run_v = run_v + 1;
      end
    end
    cnt_o      = CNT_W'(cnt_v);
    next_run_o = IDX_W'(run_v);
  end

endmodule

// File: rtl/sparse_vector_compressor.sv
// rtl/sparse_vector_compressor.sv - streaming zero-skip compressor top; SVC_BITMASK_EN adds out_mask_o
module sparse_vector_compressor
  import svc_pkg::*;
#(
  parameter int DATA_W  = SVC_DATA_W,
  parameter int VEC_LEN = SVC_VEC_LEN,
  parameter int MAX_RUN = SVC_MAX_RUN,
  parameter int IDX_W   = svc_idx_w(MAX_RUN),
  parameter int CNT_W   = svc_cnt_w(VEC_LEN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_W*VEC_LEN-1:0] in_data_i,
  input  logic                      in_last_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W*VEC_LEN-1:0] out_data_o,
  output logic [IDX_W*VEC_LEN-1:0]  out_idx_o,
  output logic [CNT_W-1:0]          out_cnt_o,
`ifdef SVC_BITMASK_EN
  output logic [VEC_LEN-1:0]        out_mask_o,
`endif
  output logic                      out_last_o
);

  svc_state_e                state_q, state_d;
  logic [IDX_W-1:0]          run_q, run_d;
  logic                      valid_q, valid_d;
  logic [DATA_W*VEC_LEN-1:0] data_q, data_d;
  logic [IDX_W*VEC_LEN-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      last_q, last_d;

  logic                      accept;
  logic [IDX_W-1:0]          carry_run;
  logic [DATA_W*VEC_LEN-1:0] k_data;
  logic [IDX_W*VEC_LEN-1:0]  k_idx;
  logic [CNT_W-1:0]          k_cnt;
  logic [IDX_W-1:0]          k_next_run;
`ifdef SVC_BITMASK_EN
  logic [VEC_LEN-1:0]        k_mask;
  logic [VEC_LEN-1:0]        mask_q, mask_d;
`endif

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign carry_run  = (state_q == STREAM) ? run_q : '0;

  svc_pack_kernel #(
    .DATA_W (DATA_W),
    .VEC_LEN(VEC_LEN),
    .MAX_RUN(MAX_RUN),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_kernel (
    .data_i     (in_data_i),
    .carry_run_i(carry_run),
    .data_o     (k_data),
    .idx_o      (k_idx),
    .cnt_o      (k_cnt),
`ifdef SVC_BITMASK_EN
    .mask_o     (k_mask),
`endif
    .next_run_o (k_next_run)
  );

  // Trailing zeros of a packet are dropped: the carried run is cleared on the last beat.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef SVC_BITMASK_EN
    mask_d  = mask_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      data_d  = k_data;
      idx_d   = k_idx;
      cnt_d   = k_cnt;
      last_d  = in_last_i;
`ifdef SVC_BITMASK_EN
      mask_d  = k_mask;
`endif
      run_d   = in_last_i ? '0 : k_next_run;
      state_d = in_last_i ? IDLE : STREAM;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
`ifdef SVC_BITMASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef SVC_BITMASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_idx_o   = idx_q;
  assign out_cnt_o   = cnt_q;
  assign out_last_o  = last_q;
`ifdef SVC_BITMASK_EN
  assign out_mask_o  = mask_q;
`endif

endmodule

// File: tb/tb_sparse_vector_compressor.sv
// tb/tb_sparse_vector_compressor.sv - scoreboard bench for sparse_vector_compressor (SVC_BITMASK_EN aware)
module tb_sparse_vector_compressor;
  import svc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [63:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data, out_idx;
  logic [4:0]  out_cnt;
`ifdef SVC_BITMASK_EN
  logic [15:0] out_mask;
`endif

  always #5 clk = ~clk;

  sparse_vector_compressor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_idx_o  (out_idx),
    .out_cnt_o  (out_cnt),
`ifdef SVC_BITMASK_EN
    .out_mask_o (out_mask),
`endif
    .out_last_o (out_last)
  );

  svc_beat_t   exp_q[$];
  logic [15:0] mask_q[$];
  svc_beat_t   mon_e;
  logic [15:0] mon_m;
  int          vectors = 0;
  int          miscompares = 0;
  int          model_run = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic svc_beat_t mk(input logic [63:0] d, input logic [63:0] i, input int c, input logic l);
    svc_beat_t b;
    b.data = d;
    b.idx  = i;
    b.cnt  = 5'(c);
    b.last = l;
    return b;
  endfunction

  // Reference scan: emit on non-zero or when the run already reached 15.
  function automatic void model(input logic [63:0] d, input logic l, output svc_beat_t b, output logic [15:0] m);
    int r, c;
    logic [3:0] e;
    r = model_run;
    c = 0;
    b = '0;
    m = '0;
    for (int k = 0; k < 16; k++) begin
      e = d[k*4 +: 4];
      if (e != 4'd0 || r == 15) begin
        b.data[c*4 +: 4] = e;
        b.idx[c*4 +: 4]  = 4'(r);
        m[k] = 1'b1;
        c++;
        r = 0;
      end else begin
        r++;
      end
    end
    b.cnt = 5'(c);
    b.last = l;
    model_run = l ? 0 : r;
  endfunction

  task automatic send(input logic [63:0] d, input logic l, input logic use_exp,
                      input svc_beat_t e, input logic [15:0] em, output int waits);
    svc_beat_t   mb;
    logic [15:0] mm;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) break;
    end
    if (waits > 200) begin
      chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
    end else begin
      model(d, l, mb, mm);
      exp_q.push_back(use_exp ? e : mb);
      mask_q.push_back(use_exp ? em : mm);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_m = mask_q.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_idx", out_idx, mon_e.idx);
        chk("out_cnt", 64'(out_cnt), 64'(mon_e.cnt));
        chk("out_last", {63'b0, out_last}, {63'b0, mon_e.last});
`ifdef SVC_BITMASK_EN
        chk("out_mask", 64'(out_mask), 64'(mon_m));
`endif
      end
    end
  end

  initial begin
    int          w;
    logic [63:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_idx", out_idx, 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    chk("rst_out_last", {63'b0, out_last}, 64'd0);
`ifdef SVC_BITMASK_EN
    chk("rst_out_mask", 64'(out_mask), 64'd0);
`endif
    rst_n = 1'b1;

    // single beat with two entries
    send(64'h5000_0000_0000_0300, 1'b1, 1'b1, mk(64'h53, 64'hC2, 2, 1'b1), 16'h8004, w);
    // run carried across beats, capped at the maximum run
    send(64'h0, 1'b0, 1'b1, mk(64'h0, 64'hF, 1, 1'b0), 16'h8000, w);
    send(64'h7, 1'b1, 1'b1, mk(64'h7, 64'h0, 1, 1'b1), 16'h0001, w);
    // trailing zeros do not cross the packet boundary
    send(64'h9, 1'b1, 1'b1, mk(64'h9, 64'h0, 1, 1'b1), 16'h0001, w);
    send(64'h40, 1'b1, 1'b1, mk(64'h4, 64'h1, 1, 1'b1), 16'h0002, w);
    drain();

    // backpressure: held output, no beat lost, then full rate
    out_ready = 1'b0;
    send(64'h0030_0000_1000_0002, 1'b0, 1'b0, '0, '0, w);
    in_data  = 64'h0000_0500_0000_0000;
    in_last  = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_out_data", out_data, exp_q[0].data);
      chk("bp_out_idx", out_idx, exp_q[0].idx);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(64'h0000_0500_0000_0000, 1'b0, 1'b0, '0, '0, w);
    chk("bp_release_wait", 64'(w), 64'd0);
    send(64'hA000_0000_0000_0000, 1'b1, 1'b0, '0, '0, w);
    chk("throughput_wait", 64'(w), 64'd0);
    drain();

    // sparse random beats
    for (int i = 0; i < 24; i++) begin
      d = '0;
      for (int k = 0; k < 16; k++)
        if ($urandom_range(3) == 0) d[k*4 +: 4] = 4'($urandom_range(15));
      send(d, ($urandom_range(3) == 0), 1'b0, '0, '0, w);
    end
    drain();

    // reset mid-packet with run=6 carried and a held output
    send(64'h0000_0010_0000_0000, 1'b0, 1'b1, mk(64'h1, 64'h9, 1, 1'b0), 16'h0200, w);
    drain();
    out_ready = 1'b0;
    send(64'h0000_0010_0000_0000, 1'b0, 1'b0, '0, '0, w);
    rst_n = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    mask_q.delete();
    model_run = 0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_out_cnt", 64'(out_cnt), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_idx", out_idx, 64'd0);
    rst_n = 1'b1;
    send(64'h40, 1'b1, 1'b1, mk(64'h4, 64'h1, 1, 1'b1), 16'h0002, w);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
